// File: rtl/spi_cmos_pkg.sv
// Shared definitions for the SPI CMOS link: transmit FSM states and
// parameter defaults used by the top level and its FIFO.
package spi_cmos_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_CLK_DIV    = 1;
    localparam bit          DEF_CPOL       = 1'b0;
    localparam bit          DEF_LSB_FIRST  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/spi_cmos_fifo.sv
// Receive word FIFO between the SPI receiver and the SPI transmitter.
// Ports: clk/rst (sync, active-high), push/push_data write side,
// pop/pop_data read side (pop_data shows the head word), count of words
// held, rd_empty/wr_full decoded from count.
// A push while full succeeds only when a pop happens in the same cycle;
// a pop while empty is ignored.
module spi_cmos_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rd_empty,
    output logic                          wr_full
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push_c;
    logic                  do_pop_c;

    assign rd_empty = (count_q == '0);
    assign wr_full  = (count_q == FULL_CNT);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        do_push_c = push & (~wr_full | pop);
        do_pop_c  = pop & ~rd_empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spi_cmos_link.sv
// SPI CMOS link: deserialises words from a sampled-data receive port
// (cs_n_in/miso, one bit per sys_clk), buffers them in a FIFO and, on each
// rising edge of ready, drains the FIFO out of an SPI master (mode CPHA=0).
// Ports: sys_clk, sys_rst (sync, active-high); cs_n_in, miso, ready in;
// cs_n_out, sck_out, mosi transmit out; fifo_count, rd_empty, wr_full FIFO
// status; overflow (sticky), frame_err (1-cycle pulse), busy (FSM not idle).
module spi_cmos_link
    import spi_cmos_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter bit          CPOL       = DEF_CPOL,
    parameter bit          LSB_FIRST  = DEF_LSB_FIRST
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          cs_n_in,
    input  logic                          miso,
    input  logic                          ready,
    output logic                          cs_n_out,
    output logic                          sck_out,
    output logic                          mosi,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rd_empty,
    output logic                          wr_full,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(2 * CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

    // Bit that goes on the wire first for a given word.
    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    // Receiver state
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [BIT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic                  rx_push_c;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;

    // Transmitter state
    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  sck_q, sck_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  ready_s_q, ready_s_d;
    logic                  ready_h_q, ready_h_d;
    logic                  ready_rise_c;
    logic                  tx_pop_c;
    logic [DATA_WIDTH-1:0] fifo_head;

    spi_cmos_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (rx_push_c),
        .push_data (rx_sr_d),
        .pop       (tx_pop_c),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .rd_empty  (rd_empty),
        .wr_full   (wr_full)
    );

    // Receiver: shift while selected, push on the last bit, discard a
    // partial word when the frame closes early.
    always_comb begin
        rx_sr_d     = rx_sr_q;
        rx_cnt_d    = rx_cnt_q;
        rx_push_c   = 1'b0;
        frame_err_d = 1'b0;
        if (!cs_n_in) begin
            if (LSB_FIRST) begin
                rx_sr_d = {miso, rx_sr_q[DATA_WIDTH-1:1]};
            end else begin
                rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
            end
            if (rx_cnt_q == BIT_LAST) begin
                rx_push_c = 1'b1;
                rx_cnt_d  = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + BIT_W'(1);
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d    = '0;
            frame_err_d = 1'b1;
        end
        overflow_d = overflow_q | (rx_push_c & wr_full & ~tx_pop_c);
    end

    // Transmit FSM. cs_n_out falls on entry to LOAD with the first bit
    // already on mosi, so the inter-frame gap is exactly the GAP state.
    always_comb begin
        state_d      = state_q;
        tx_sr_d      = tx_sr_q;
        tx_bit_d     = tx_bit_q;
        div_d        = div_q;
        gap_d        = gap_q;
        sck_d        = sck_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;
        tx_pop_c     = 1'b0;
        ready_s_d    = ready;
        ready_h_d    = ready_s_q;
        ready_rise_c = ready_s_q & ~ready_h_q;
        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = CPOL;
                mosi_d = 1'b0;
                if (ready_rise_c && !rd_empty) begin
                    state_d = ST_LOAD;
                    cs_n_d  = 1'b0;
                    mosi_d  = lead_bit(fifo_head);
                end
            end
            ST_LOAD: begin
                tx_pop_c = 1'b1;
                tx_sr_d  = fifo_head;
                tx_bit_d = '0;
                div_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    // Leaving the active level is the trailing edge.
                    if (sck_q != CPOL) begin
                        if (tx_bit_q == BIT_LAST) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            tx_bit_d = tx_bit_q + BIT_W'(1);
                            tx_sr_d  = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                            mosi_d   = lead_bit(tx_sr_d);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!rd_empty) begin
                        state_d = ST_LOAD;
                        cs_n_d  = 1'b0;
                        mosi_d  = lead_bit(fifo_head);
                    end else begin
                        state_d = ST_IDLE;
                        mosi_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_sr_q     <= '0;
            rx_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            tx_bit_q    <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            sck_q       <= CPOL;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_s_q   <= 1'b0;
            ready_h_q   <= 1'b0;
        end else begin
            rx_sr_q     <= rx_sr_d;
            rx_cnt_q    <= rx_cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            tx_bit_q    <= tx_bit_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            sck_q       <= sck_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            ready_s_q   <= ready_s_d;
            ready_h_q   <= ready_h_d;
        end
    end

    assign cs_n_out  = cs_n_q;
    assign sck_out   = sck_q;
    assign mosi      = mosi_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_cmos_link.sv
// Self-checking bench for spi_cmos_link with default parameters.
// Inputs change and outputs are sampled on the falling edge of sys_clk.
// A passive SPI slave model decodes every transmitted frame; expected words
// come from a queue model of the FIFO.
module tb_spi_cmos_link;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cs_n_in = 1'b1;
    logic       miso    = 1'b0;
    logic       ready   = 1'b0;
    logic       cs_n_out, sck_out, mosi;
    logic [4:0] fifo_count;
    logic       rd_empty, wr_full, overflow, frame_err, busy;

    spi_cmos_link dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cs_n_in    (cs_n_in),
        .miso       (miso),
        .ready      (ready),
        .cs_n_out   (cs_n_out),
        .sck_out    (sck_out),
        .mosi       (mosi),
        .fifo_count (fifo_count),
        .rd_empty   (rd_empty),
        .wr_full    (wr_full),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // ---------------- passive SPI slave model (mode 0, MSB first) -------------
    logic [31:0] cap_word [$];
    int          cap_bits [$];
    int          cap_hi   [$];
    int          gaps     [$];
    int          fe_pulses = 0;
    int          mosi_bad  = 0;
    int          cs_low    = 0;

    initial begin
        logic        prev_cs, prev_sck, prev_mosi;
        logic [31:0] cur_word;
        int          cur_bits, cur_hi, gap_run;
        prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
        cur_word = '0; cur_bits = 0; cur_hi = 0; gap_run = 0;
        forever begin
            @(negedge sys_clk);
            if (frame_err) fe_pulses++;
            if (prev_cs && !cs_n_out) begin
                if (gap_run > 0) gaps.push_back(gap_run);
                cur_word = '0; cur_bits = 0; cur_hi = 0;
            end
            if (!cs_n_out) begin
                cs_low++;
                if (!prev_sck && sck_out) begin
                    cur_word = {cur_word[30:0], mosi};
                    cur_bits++;
                end
                if (sck_out) cur_hi++;
                if (!prev_cs && (mosi !== prev_mosi) && !(prev_sck && !sck_out)) mosi_bad++;
            end
            if (!prev_cs && cs_n_out) begin
                cap_word.push_back(cur_word);
                cap_bits.push_back(cur_bits);
                cap_hi.push_back(cur_hi);
            end
            gap_run   = (cs_n_out && busy) ? gap_run + 1 : 0;
            prev_cs   = cs_n_out;
            prev_sck  = sck_out;
            prev_mosi = mosi;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; cs_n_in = 1'b1; miso = 1'b0; ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            cs_n_in = 1'b0; miso = w[i];
            @(negedge sys_clk);
        end
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cs_n_in = 1'b0; miso = 1'($urandom_range(0, 1));
            @(negedge sys_clk);
        end
    endtask

    task automatic idle(input int n);
        cs_n_in = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        cs_n_in = 1'b1;
        repeat (4) @(negedge sys_clk);
        while (busy && k < 5000) begin
            @(negedge sys_clk);
            k++;
        end
        check(name, 64'(busy), 64'(0));
    endtask

    // Compare frames captured since index base with the expected word list.
    task automatic check_frames(input string name, input int base, input logic [31:0] exp_w [$]);
        check({name, "_nframes"}, 64'(cap_word.size() - base), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && base + i < cap_word.size(); i++) begin
            check($sformatf("%s_word%0d", name, i), 64'(cap_word[base + i]), 64'(exp_w[i]));
            check($sformatf("%s_bits%0d", name, i), 64'(cap_bits[base + i]), 64'(W));
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] exp_q [$];
    int          lat;

    initial begin
        int base, gbase, fe0, mb0, cl0, n, m, npart, k, lead;
        logic prev;
        logic [31:0] w17;

        // Table: 17 back-to-back words; the 17th finds the FIFO full.
        for (int i = 0; i < 17; i++) begin
            vecs[i].word      = $urandom;
            vecs[i].exp_count = (i + 1 > DEPTH) ? DEPTH : i + 1;
            vecs[i].exp_empty = 1'b0;
            vecs[i].exp_full  = (i >= DEPTH - 1);
            vecs[i].exp_ovf   = (i >= DEPTH);
        end
        vecs[0].word = 32'h02E5CB94;
        vecs[1].word = 32'h1152C5CA;
        vecs[2].word = 32'hA5A5A5A5;

        // ---- reset state ----
        do_reset();
        check("rst_cs_n_out", 64'(cs_n_out), 64'(1));
        check("rst_sck_out", 64'(sck_out), 64'(0));
        check("rst_mosi", 64'(mosi), 64'(0));
        check("rst_fifo_count", 64'(fifo_count), 64'(0));
        check("rst_rd_empty", 64'(rd_empty), 64'(1));
        check("rst_wr_full", 64'(wr_full), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // ---- single word receive ----
        fe0 = fe_pulses;
        send_word(32'h02E5CB94);
        check("one_word_count", 64'(fifo_count), 64'(1));
        check("one_word_empty", 64'(rd_empty), 64'(0));
        idle(3);
        check("one_word_no_ferr", 64'(fe_pulses - fe0), 64'(0));
        base = cap_word.size();
        ready = 1'b1;
        wait_idle("one_word_drain");
        ready = 1'b0;
        exp_q = {32'h02E5CB94};
        check_frames("one_word_tx", base, exp_q);

        // ---- partial frame discarded, then a clean word ----
        do_reset();
        fe0 = fe_pulses;
        send_partial(10);
        idle(4);
        check("partial_ferr_pulses", 64'(fe_pulses - fe0), 64'(1));
        check("partial_count", 64'(fifo_count), 64'(0));
        send_word(32'h5A0FF0C3);
        check("after_partial_count", 64'(fifo_count), 64'(1));
        base = cap_word.size();
        ready = 1'b1;
        wait_idle("after_partial_drain");
        ready = 1'b0;
        exp_q = {32'h5A0FF0C3};
        check_frames("after_partial_tx", base, exp_q);

        // ---- fill to overflow from the table ----
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_word(vecs[i].word);
            check($sformatf("fill%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
            check($sformatf("fill%0d_empty", i), 64'(rd_empty), 64'(vecs[i].exp_empty));
            check($sformatf("fill%0d_full", i), 64'(wr_full), 64'(vecs[i].exp_full));
            check($sformatf("fill%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
        end
        base = cap_word.size();
        ready = 1'b1;
        wait_idle("fill_drain");
        ready = 1'b0;
        exp_q = {};
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(vecs[i].word);
        check_frames("fill_tx", base, exp_q);
        check("fill_ovf_sticky", 64'(overflow), 64'(1));
        check("fill_drained_empty", 64'(rd_empty), 64'(1));

        // ---- three-word drain: timing, gaps and mosi stability ----
        do_reset();
        exp_q = {};
        for (int i = 0; i < 3; i++) begin
            send_word(vecs[i].word);
            exp_q.push_back(vecs[i].word);
            idle(2);
        end
        check("three_count", 64'(fifo_count), 64'(3));
        base = cap_word.size(); gbase = gaps.size(); mb0 = mosi_bad;
        ready = 1'b1;
        lat = 0;
        while (cs_n_out && lat < 50) begin
            @(negedge sys_clk);
            lat++;
        end
        check("three_drain_start", 64'(cs_n_out), 64'(0));
        wait_idle("three_drain");
        ready = 1'b0;
        check_frames("three_tx", base, exp_q);
        for (int i = 0; i < 3 && base + i < cap_hi.size(); i++)
            check($sformatf("three_sck_hi%0d", i), 64'(cap_hi[base + i]), 64'(W));
        check("three_ngaps", 64'(gaps.size() - gbase), 64'(2));
        for (int i = gbase; i < gaps.size(); i++)
            check($sformatf("three_gap%0d", i - gbase), 64'(gaps[i]), 64'(2));
        check("three_mosi_stable", 64'(mosi_bad - mb0), 64'(0));
        check("three_empty", 64'(rd_empty), 64'(1));

        // ---- full FIFO, push lands on the first pop ----
        do_reset();
        exp_q = {};
        for (int i = 0; i < DEPTH; i++) begin
            send_word(vecs[i].word);
            exp_q.push_back(vecs[i].word);
        end
        check("full_before", 64'(wr_full), 64'(1));
        w17 = $urandom;
        exp_q.push_back(w17);
        base = cap_word.size();
        lead = (lat > 31) ? 0 : 31 - lat;
        for (int i = 0; i < 32; i++) begin
            if (i == lead) ready = 1'b1;
            cs_n_in = 1'b0; miso = w17[31 - i];
            @(negedge sys_clk);
        end
        ready = 1'b1;
        check("full_pushpop_count", 64'(fifo_count), 64'(DEPTH));
        check("full_pushpop_ovf", 64'(overflow), 64'(0));
        wait_idle("full_drain");
        ready = 1'b0;
        check_frames("full_tx", base, exp_q);
        check("full_after_ovf", 64'(overflow), 64'(0));

        // ---- reset in the middle of a frame ----
        do_reset();
        send_word($urandom);
        idle(1);
        ready = 1'b1;
        k = 0;
        while (cs_n_out && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        n = 0; k = 0; prev = sck_out;
        while (n < 12 && k < 200) begin
            @(negedge sys_clk);
            if (!prev && sck_out) n++;
            prev = sck_out;
            k++;
        end
        check("midrst_reached_bit12", 64'(n), 64'(12));
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_cs_n_out", 64'(cs_n_out), 64'(1));
        check("midrst_sck_out", 64'(sck_out), 64'(0));
        check("midrst_mosi", 64'(mosi), 64'(0));
        check("midrst_count", 64'(fifo_count), 64'(0));
        check("midrst_empty", 64'(rd_empty), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        sys_rst = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        cl0 = cs_low;
        ready = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("midrst_empty_edge_busy", 64'(busy), 64'(0));
        check("midrst_empty_edge_cs", 64'(cs_low - cl0), 64'(0));
        ready = 1'b0;

        // ---- randomized rounds against the queue model ----
        for (int r = 0; r < 4; r++) begin
            do_reset();
            exp_q = {};
            base = cap_word.size(); fe0 = fe_pulses; mb0 = mosi_bad;
            npart = 0;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                w17 = $urandom;
                send_word(w17);
                exp_q.push_back(w17);
                idle($urandom_range(1, 3));
            end
            check($sformatf("rnd%0d_count", r), 64'(fifo_count), 64'(exp_q.size()));
            ready = 1'b1;
            m = $urandom_range(0, 2);
            for (int j = 0; j < m; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    send_partial($urandom_range(1, 20));
                    idle(2);
                    npart++;
                end
                w17 = $urandom;
                send_word(w17);
                exp_q.push_back(w17);
                idle($urandom_range(1, 3));
            end
            wait_idle($sformatf("rnd%0d_drain", r));
            ready = 1'b0;
            check_frames($sformatf("rnd%0d_tx", r), base, exp_q);
            check($sformatf("rnd%0d_ferr", r), 64'(fe_pulses - fe0), 64'(npart));
            check($sformatf("rnd%0d_left", r), 64'(fifo_count), 64'(0));
            check($sformatf("rnd%0d_mosi_stable", r), 64'(mosi_bad - mb0), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_cmos_link.md
SPI_CMOS_LINK -- requirements
Module: spi_cmos_link

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per SPI word, both directions, range 8..32.
REQ-002 Parameter FIFO_DEPTH, default 16: receive FIFO words, power of two, at least 2.
REQ-003 Parameter CLK_DIV, default 1: sys_clk cycles per sck_out half-period, at least 1.
REQ-004 Parameter CPOL, default 0: idle level of sck_out.
REQ-005 Parameter LSB_FIRST, default 0: 0 shifts MSB first, 1 shifts LSB first (both directions).
REQ-006 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-007 sys_rst  in  1  reset, synchronous, active-high.
REQ-008 cs_n_in  in  1  receive frame select, active low.
REQ-009 miso  in  1  receive data, sampled every sys_clk while cs_n_in=0.
REQ-010 ready  in  1  level input; each rising edge arms one FIFO drain.
REQ-011 cs_n_out  out  1  transmit frame select, active low.
REQ-012 sck_out  out  1  transmit serial clock.
REQ-013 mosi  out  1  transmit data.
REQ-014 fifo_count  out  clog2(FIFO_DEPTH)+1  words held.
REQ-015 rd_empty / wr_full  out  1 each  FIFO flags, driven combinationally from fifo_count.
REQ-016 overflow  out  1  sticky: a completed word was dropped.
REQ-017 frame_err  out  1  one-cycle pulse: a partial word was discarded.
REQ-018 busy  out  1  high whenever the transmit FSM is not in IDLE.

Function
REQ-019 Receiver shall shift miso into a DATA_WIDTH shift register and increment a bit counter each cycle cs_n_in=0.
REQ-020 On the cycle the DATA_WIDTH-th bit is sampled, the receiver shall write the word, with fifo_count updating 1 cycle later; the counter restarts so back-to-back words need no cs_n_in deassertion.
REQ-021 A cs_n_in 0->1 transition with bit counter in 1..DATA_WIDTH-1 shall discard the partial word, clear the counter and pulse frame_err for 1 cycle.
REQ-022 A write while wr_full=1 and no pop in that cycle shall be dropped, set overflow (cleared only by sys_rst) and leave fifo_count unchanged.
REQ-023 A push and pop in the same cycle shall both succeed and leave fifo_count unchanged, including at full and at empty+push (no bypass: pop at empty is never issued).
REQ-024 FIFO pointers shall wrap modulo FIFO_DEPTH; words shall exit in write order.
REQ-025 Transmit FSM states: IDLE, LOAD, SHIFT, GAP.
REQ-026 IDLE->LOAD on registered ready rising edge with rd_empty=0; a rising edge while rd_empty=1 shall be ignored; edges outside IDLE shall be ignored.
REQ-027 LOAD (1 cycle): pop one word into the transmit shift register, drive cs_n_out=0, present first bit on mosi; ->SHIFT.
REQ-028 SHIFT: sck_out toggles every CLK_DIV cycles; mosi changes only on the trailing edge (valid before every leading edge, mode CPHA=0); after DATA_WIDTH leading edges and the final trailing edge, sck_out returns to CPOL, cs_n_out=1; ->GAP.
REQ-029 GAP: hold cs_n_out=1 for 2*CLK_DIV cycles, then ->LOAD if rd_empty=0, else ->IDLE (drain continues until empty).
REQ-030 Words received during a drain shall be transmitted by that same drain.
REQ-031 In IDLE: cs_n_out=1, sck_out=CPOL, mosi=0.

Reset
REQ-032 sys_rst=1 at any sys_clk edge, including mid-frame, shall force next cycle: FSM IDLE, cs_n_out=1, sck_out=CPOL, mosi=0, fifo_count=0, rd_empty=1, wr_full=0, overflow=0, frame_err=0, busy=0, counters and pointers 0, ready edge detector history = 0.
REQ-033 FIFO storage contents need not be reset.

Structure
REQ-034 Package spi_cmos_pkg shall hold the transmit state enumeration and the parameter defaults.
REQ-035 FIFO shall be a sub-module spi_cmos_fifo (parameters DATA_WIDTH, FIFO_DEPTH; push, pop, count, flags).

Verification
REQ-036 Defaults; cs_n_in=0 for 32 cycles sending MSB-first 0x02E5CB94 -> fifo_count=1 one cycle after bit 32, rd_empty=0, frame_err never pulses.
REQ-037 cs_n_in=0 for 10 bits then 1 -> frame_err pulses exactly 1 cycle, fifo_count stays 0.
REQ-038 17 back-to-back words, no drain -> wr_full=1 after word 16, overflow=1 after word 17, fifo_count=16.
REQ-039 3 words (0x02E5CB94, 0x1152C5CA, 0xA5A5A5A5), then ready 0->1 -> 3 frames, each 32 sck_out periods of 2 sys_clk; mosi decodes identical values in order; cs_n_out high 2 cycles between frames; busy falls, rd_empty=1.
REQ-040 Full FIFO, drain active, simultaneous push on LOAD cycle -> word accepted, fifo_count stays 16, overflow=0.
REQ-041 sys_rst=1 during SHIFT bit 12 -> next cycle cs_n_out=1, sck_out=0, fifo_count=0, busy=0; later ready edge with empty FIFO -> stays IDLE.
